// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: shared definitions for the data-memory responder.
//   state_t        - responder FSM states (IDLE, BUSY, RESP)
//   WORD_W         - data word width
//   BYTE_OFF_W     - width of the byte offset inside a word address
//   ERR_*          - bit positions of the error-reason vector (debug aid)
//   req_err()      - decodes a request into its error-reason vector
package mips_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    localparam int unsigned WORD_W     = 32;
    localparam int unsigned BYTE_OFF_W = 2;

    localparam int unsigned ERR_MISALIGN = 0;
    localparam int unsigned ERR_RANGE    = 1;
    localparam int unsigned ERR_CONFLICT = 2;
    localparam int unsigned ERR_W        = 3;

    // One bit per reason; any set bit makes the request an error.
    function automatic logic [ERR_W-1:0] req_err(
        input logic [WORD_W-1:0] adr,
        input logic              rd,
        input logic              wr,
        input int unsigned       addr_w
    );
        logic [ERR_W-1:0] r;
        r               = '0;
        r[ERR_MISALIGN] = (adr[BYTE_OFF_W-1:0] != '0);
        r[ERR_RANGE]    = ((adr >> (addr_w + BYTE_OFF_W)) != '0);
        r[ERR_CONFLICT] = rd & wr;
        return r;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: core <-> data-memory handshake bundle.
//   data_adr   - byte address (core -> memory)
//   data_wdata - store data   (core -> memory)
//   mem_read   - load request, held until mem_ready
//   mem_write  - store request, held until mem_ready
//   data_rdata - load data, valid only with mem_ready
//   mem_ready  - one-cycle completion pulse
//   mem_err    - error flag, valid only with mem_ready
// Modports: master = core side, slave = memory side.
interface dmem_responder_if;
    import mips_mem_pkg::*;

    logic [WORD_W-1:0] data_adr;
    logic [WORD_W-1:0] data_wdata;
    logic              mem_read;
    logic              mem_write;
    logic [WORD_W-1:0] data_rdata;
    logic              mem_ready;
    logic              mem_err;

    modport master (
        output data_adr, data_wdata, mem_read, mem_write,
        input  data_rdata, mem_ready, mem_err
    );

    modport slave (
        input  data_adr, data_wdata, mem_read, mem_write,
        output data_rdata, mem_ready, mem_err
    );

endinterface

// File: rtl/dmem_array.sv
// dmem_array: synchronous single-port DEPTH x WORD_W RAM, no reset.
//   clk     - clock
//   we_i    - write enable
//   idx_i   - word index
//   wdata_i - write data
//   rdata_o - registered read data (read-before-write on the same index)
module dmem_array
    import mips_mem_pkg::*;
#(
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] idx_i,
    input  logic [WORD_W-1:0] wdata_i,
    output logic [WORD_W-1:0] rdata_o
);

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[idx_i] <= wdata_i;
        end
        rdata_q <= mem_q[idx_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data-memory responder for the MIPS core.
// Accepts a load/store in IDLE, waits LATENCY cycles, then pulses
// mem_ready for one cycle, flagging misaligned, out-of-range and
// read+write conflicting requests on mem_err.
//   clk      - clock, rising edge
//   rst      - asynchronous active-low reset
//   bus      - dmem_responder_if.slave (address, data, handshake)
//   rd_count - successful loads  (only with DMEM_STATS_EN defined)
//   wr_count - successful stores (only with DMEM_STATS_EN defined)
// Optional feature macro: DMEM_STATS_EN.
module dmem_responder
    import mips_mem_pkg::*;
#(
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned LATENCY = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    dmem_responder_if.slave         bus
`ifdef DMEM_STATS_EN
    ,
    output logic [31:0]             rd_count,
    output logic [31:0]             wr_count
`endif
);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [WORD_W-1:0] adr_q, adr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;

    logic              arr_we;
    logic [WORD_W-1:0] arr_rdata;
    logic              rsp_err;

    // State register and latched request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            adr_q   <= '0;
            wdata_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            adr_q   <= adr_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
        end
    end

    // Next state. The counter holds the cycles still to wait; the last
    // decrement (1 -> 0) is the edge that enters RESP.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        adr_d   = adr_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        case (state_q)
            IDLE: begin
                if (bus.mem_read || bus.mem_write) begin
                    adr_d   = bus.data_adr;
                    wdata_d = bus.data_wdata;
                    rd_d    = bus.mem_read;
                    wr_d    = bus.mem_write;
                    cnt_d   = 4'(LATENCY - 1);
                    state_d = (LATENCY == 1) ? RESP : BUSY;
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The array is accessed on the edge entering RESP. The *_d request
    // values are used so that LATENCY==1 (entry straight from IDLE, same
    // edge as the latch) sees the request being accepted.
    assign arr_we = (state_q != RESP) && (state_d == RESP) && wr_d
                    && (req_err(adr_d, rd_d, wr_d, ADDR_W) == '0);

    dmem_array #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk     (clk),
        .we_i    (arr_we),
        .idx_i   (adr_d[ADDR_W+BYTE_OFF_W-1:BYTE_OFF_W]),
        .wdata_i (wdata_d),
        .rdata_o (arr_rdata)
    );

    assign rsp_err = |req_err(adr_q, rd_q, wr_q, ADDR_W);

    // Outputs: all sources are registers, so they hold for the RESP cycle.
    always_comb begin
        bus.mem_ready  = 1'b0;
        bus.mem_err    = 1'b0;
        bus.data_rdata = '0;
        if (state_q == RESP) begin
            bus.mem_ready = 1'b1;
            bus.mem_err   = rsp_err;
            if (rd_q && !rsp_err) begin
                bus.data_rdata = arr_rdata;
            end
        end
    end

`ifdef DMEM_STATS_EN
    logic [31:0] rd_count_q, wr_count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_count_q <= '0;
            wr_count_q <= '0;
        end else if (state_q == RESP && !rsp_err) begin
            if (rd_q) rd_count_q <= rd_count_q + 32'd1;
            if (wr_q) wr_count_q <= wr_count_q + 32'd1;
        end
    end

    assign rd_count = rd_count_q;
    assign wr_count = wr_count_q;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: scoreboard bench for dmem_responder (DEPTH=1024,
// LATENCY=3). Expected responses are queued when a request is driven and
// compared when mem_ready is observed. Define DMEM_STATS_EN to also check
// the operation counters.
module tb_dmem_responder;

    localparam int unsigned LAT = 3;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    logic clk;
    logic rst;

    dmem_responder_if bus ();

`ifdef DMEM_STATS_EN
    logic [31:0] rd_count, wr_count;
`endif

    dmem_responder #(
        .DEPTH   (1024),
        .ADDR_W  (10),
        .LATENCY (LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef DMEM_STATS_EN
        ,
        .rd_count (rd_count),
        .wr_count (wr_count)
`endif
    );

    int unsigned nvec = 0;
    int unsigned nerr = 0;
    exp_t        exp_q [$];
    logic [31:0] model [int unsigned];
    int unsigned exp_rd = 0;
    int unsigned exp_wr = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Response monitor: pops one expectation per mem_ready pulse and checks
    // that outputs stay quiet otherwise.
    always @(negedge clk) begin
        exp_t e;
        if (bus.mem_ready === 1'b1) begin
            check("ready_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("rsp_err", 32'(bus.mem_err), 32'(e.err));
                check("rsp_rdata", bus.data_rdata, e.rdata);
            end
        end else begin
            check("idle_rdata", bus.data_rdata, 32'd0);
            check("idle_err", 32'(bus.mem_err), 32'd0);
        end
    end

    task automatic do_req(input logic rd, input logic wr, input logic [31:0] adr, input logic [31:0] wd);
        exp_t        e;
        logic        bad;
        int unsigned n;
        logic        got;
        bad = (adr[1:0] != 2'b00) || (adr >= 32'h0000_1000) || (rd && wr);
        e.err   = bad;
        e.rdata = 32'd0;
        if (!bad && rd) e.rdata = model.exists(adr >> 2) ? model[adr >> 2] : 32'd0;
        if (!bad && wr) model[adr >> 2] = wd;
        if (!bad && rd) exp_rd++;
        if (!bad && wr) exp_wr++;
        exp_q.push_back(e);

        @(posedge clk);
        #1;
        bus.data_adr   = adr;
        bus.data_wdata = wd;
        bus.mem_read   = rd;
        bus.mem_write  = wr;

        n   = 0;
        got = 1'b0;
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            if (bus.mem_ready === 1'b1) got = 1'b1;
        end
        // Sampled one negedge inside the request cycle, then one per wait cycle.
        check("latency", n, LAT + 1);
        if (!got) exp_q.delete();

        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        @(negedge clk);
        check("single_pulse", 32'(bus.mem_ready), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b0;
        bus.data_adr   = '0;
        bus.data_wdata = '0;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        #7;
        check("rst_ready", 32'(bus.mem_ready), 32'd0);
        check("rst_err", 32'(bus.mem_err), 32'd0);
        check("rst_rdata", bus.data_rdata, 32'd0);
        #13;
        rst = 1'b1;

        // Store then load back.
        do_req(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
        do_req(1'b1, 1'b0, 32'h10, 32'h0);
        // Misaligned load.
        do_req(1'b1, 1'b0, 32'h13, 32'h0);
        // Out-of-range store must not disturb word 0.
        do_req(1'b0, 1'b1, 32'h0, 32'hCAFEF00D);
        do_req(1'b0, 1'b1, 32'h1000, 32'hFFFFFFFF);
        do_req(1'b1, 1'b0, 32'h0, 32'h0);
        // Conflicting read+write, then misaligned store, to a live word.
        do_req(1'b0, 1'b1, 32'h20, 32'h12345678);
        do_req(1'b1, 1'b1, 32'h20, 32'hBAD0BAD0);
        do_req(1'b1, 1'b0, 32'h20, 32'h0);
        do_req(1'b0, 1'b1, 32'h22, 32'h55555555);
        do_req(1'b1, 1'b0, 32'h20, 32'h0);
        // Top word and far out-of-range address.
        do_req(1'b0, 1'b1, 32'hFFC, 32'h0BADF00D);
        do_req(1'b1, 1'b0, 32'hFFC, 32'h0);
        do_req(1'b1, 1'b0, 32'hFFFFFFFC, 32'h0);

        // Reset during BUSY aborts the pending store.
        do_req(1'b0, 1'b1, 32'h40, 32'h11112222);
        @(posedge clk);
        #1;
        bus.data_adr   = 32'h40;
        bus.data_wdata = 32'hA5A5A5A5;
        bus.mem_write  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_ready", 32'(bus.mem_ready), 32'd0);
        bus.mem_write = 1'b0;
        exp_rd = 0;
        exp_wr = 0;
        #20;
        rst = 1'b1;
        do_req(1'b1, 1'b0, 32'h40, 32'h0);

        // Fill a window, then random back-to-back traffic within it.
        for (int i = 0; i < 16; i++) begin
            do_req(1'b0, 1'b1, 32'h100 + 32'(i) * 4, $urandom);
        end
        for (int i = 0; i < 24; i++) begin
            int unsigned k;
            k = $urandom_range(0, 15);
            if ($urandom_range(0, 1) == 1)
                do_req(1'b0, 1'b1, 32'h100 + 32'(k) * 4, $urandom);
            else
                do_req(1'b1, 1'b0, 32'h100 + 32'(k) * 4, 32'h0);
        end

`ifdef DMEM_STATS_EN
        check("rd_count", rd_count, exp_rd);
        check("wr_count", wr_count, exp_wr);
`endif
        check("queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
